// File: rtl/hdmi_tile_rd_timing.sv
// Raster timing generator with one-hot tiled frame-buffer read enables, pixel coordinates and frame strobe.
// Optional read-underflow monitor is compiled in when HDMI_RD_UNDERFLOW_EN is defined.
module hdmi_tile_rd_timing #(
    parameter int H_ACTIVE  = 1920,
    parameter int H_FP      = 88,
    parameter int H_SYNC    = 44,
    parameter int H_BP      = 148,
    parameter int V_ACTIVE  = 1080,
    parameter int V_FP      = 4,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 36,
    parameter bit HS_POL    = 1'b1,
    parameter bit VS_POL    = 1'b1,
    parameter int TILE_COLS = 2,
    parameter int TILE_ROWS = 2,
    parameter int CNT_W     = 12
) (
    input  logic                           hdmi_clk,
    input  logic                           sys_rst_n,
    input  logic                           timing_en,
    input  logic                           data_rd_valid,
    output logic                           hdmi_hs_out,
    output logic                           hdmi_vs_out,
    output logic                           hdmi_de_out,
    output logic [TILE_COLS*TILE_ROWS-1:0] tile_rden,
    output logic [3:0]                     tile_idx,
    output logic [CNT_W-1:0]               active_x,
    output logic [CNT_W-1:0]               active_y,
    output logic                           frame_start,
    output logic                           rd_underflow,
    output logic [15:0]                    underflow_cnt
);
    localparam int H_ACT_S = H_FP + H_SYNC + H_BP;
    localparam int H_TOTAL = H_ACT_S + H_ACTIVE;
    localparam int V_ACT_S = V_FP + V_SYNC + V_BP;
    localparam int V_TOTAL = V_ACT_S + V_ACTIVE;
    localparam int TILES   = TILE_COLS * TILE_ROWS;
    localparam int TILE_W  = H_ACTIVE / TILE_COLS;
    localparam int TILE_H  = V_ACTIVE / TILE_ROWS;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_LO  = CNT_W'(H_ACT_S);
    localparam logic [CNT_W-1:0] V_ACT_LO  = CNT_W'(V_ACT_S);
    localparam logic [TILES-1:0] RDEN_ONE  = TILES'(1);

    generate
        if (TILE_COLS < 1 || TILE_COLS > 4 || TILE_ROWS < 1 || TILE_ROWS > 4) begin : g_chk_tiles
            $error("TILE_COLS and TILE_ROWS must each be in 1..4");
        end
        if ((H_ACTIVE % TILE_COLS) != 0 || (V_ACTIVE % TILE_ROWS) != 0) begin : g_chk_div
            $error("H_ACTIVE/V_ACTIVE must be divisible by TILE_COLS/TILE_ROWS");
        end
        if (CNT_W < 1 || CNT_W > 30 || H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_chk_cnt
            $error("CNT_W too small for H_TOTAL/V_TOTAL or out of range");
        end
    endgenerate

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic [TILES-1:0] rden_q, rden_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;

    logic             h_sync_s, v_sync_s, de_s, fs_s;
    logic [CNT_W-1:0] x_s, y_s;
    logic [3:0]       col_s, row_s, idx_s;

    // Counter advance; both counters are pinned to the frame origin while disabled.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!timing_en) begin
            h_cnt_d = CNT_ZERO;
            v_cnt_d = CNT_ZERO;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = CNT_ZERO;
            v_cnt_d = (v_cnt_q == V_LAST) ? CNT_ZERO : (v_cnt_q + CNT_ONE);
        end else begin
            h_cnt_d = h_cnt_q + CNT_ONE;
        end
    end

    // Region decode of the current counters; tile position by counting crossed boundaries.
    always_comb begin
        h_sync_s = (h_cnt_q >= H_SYNC_LO) && (h_cnt_q < H_SYNC_HI);
        v_sync_s = (v_cnt_q >= V_SYNC_LO) && (v_cnt_q < V_SYNC_HI);
        de_s     = (h_cnt_q >= H_ACT_LO) && (v_cnt_q >= V_ACT_LO);
        x_s      = h_cnt_q - H_ACT_LO;
        y_s      = v_cnt_q - V_ACT_LO;
        col_s    = 4'd0;
        row_s    = 4'd0;
        for (int c = 1; c < TILE_COLS; c++) begin
            col_s = col_s + ((x_s >= CNT_W'(c * TILE_W)) ? 4'd1 : 4'd0);
        end
        for (int r = 1; r < TILE_ROWS; r++) begin
            row_s = row_s + ((y_s >= CNT_W'(r * TILE_H)) ? 4'd1 : 4'd0);
        end
        idx_s = (row_s * 4'(TILE_COLS)) + col_s;
        fs_s  = de_s && (x_s == CNT_ZERO) && (y_s == CNT_ZERO);
    end

    // Next values of the registered raster outputs; coordinates and tile index hold through blanking.
    always_comb begin
        hs_d   = ~HS_POL;
        vs_d   = ~VS_POL;
        de_d   = 1'b0;
        fs_d   = 1'b0;
        rden_d = {TILES{1'b0}};
        idx_d  = idx_q;
        x_d    = x_q;
        y_d    = y_q;
        if (!timing_en) begin
            idx_d = 4'd0;
            x_d   = CNT_ZERO;
            y_d   = CNT_ZERO;
        end else begin
            hs_d = h_sync_s ? HS_POL : ~HS_POL;
            vs_d = v_sync_s ? VS_POL : ~VS_POL;
            if (de_s) begin
                de_d   = 1'b1;
                fs_d   = fs_s;
                rden_d = RDEN_ONE << idx_s;
                idx_d  = idx_s;
                x_d    = x_s;
                y_d    = y_s;
            end else begin
                de_d   = 1'b0;
                rden_d = {TILES{1'b0}};
            end
        end
    end

    // Counter and output registers.
    always_ff @(posedge hdmi_clk) begin
        if (!sys_rst_n) begin
            h_cnt_q <= CNT_ZERO;
            v_cnt_q <= CNT_ZERO;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            rden_q  <= {TILES{1'b0}};
            idx_q   <= 4'd0;
            x_q     <= CNT_ZERO;
            y_q     <= CNT_ZERO;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
            rden_q  <= rden_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign hdmi_hs_out = hs_q;
    assign hdmi_vs_out = vs_q;
    assign hdmi_de_out = de_q;
    assign frame_start = fs_q;
    assign tile_rden   = rden_q;
    assign tile_idx    = idx_q;
    assign active_x    = x_q;
    assign active_y    = y_q;

`ifdef HDMI_RD_UNDERFLOW_EN
    logic        uf_s;
    logic        uf_flag_q, uf_flag_d;
    logic [15:0] uf_frame_q, uf_frame_d, uf_cnt_q, uf_cnt_d;

    // data_rd_valid qualifies the pixel currently presented on the de output.
    assign uf_s = de_q & ~data_rd_valid;

    // Per-frame saturating tally, snapshotted and restarted on the frame_start pixel.
    always_comb begin
        uf_flag_d  = uf_flag_q | uf_s;
        uf_cnt_d   = uf_cnt_q;
        uf_frame_d = uf_frame_q;
        if (fs_q) begin
            uf_cnt_d   = uf_frame_q;
            uf_frame_d = uf_s ? 16'd1 : 16'd0;
        end else if (uf_s && (uf_frame_q != 16'hFFFF)) begin
            uf_frame_d = uf_frame_q + 16'd1;
        end else begin
            uf_frame_d = uf_frame_q;
        end
    end

    // Underflow state registers; only reset clears them.
    always_ff @(posedge hdmi_clk) begin
        if (!sys_rst_n) begin
            uf_flag_q  <= 1'b0;
            uf_frame_q <= 16'd0;
            uf_cnt_q   <= 16'd0;
        end else begin
            uf_flag_q  <= uf_flag_d;
            uf_frame_q <= uf_frame_d;
            uf_cnt_q   <= uf_cnt_d;
        end
    end

    assign rd_underflow  = uf_flag_q;
    assign underflow_cnt = uf_cnt_q;
`else
    logic unused_rd_valid_s;
    assign unused_rd_valid_s = data_rd_valid;
    assign rd_underflow      = 1'b0;
    assign underflow_cnt     = 16'd0;
`endif

endmodule
